// File: rtl/branch_pkg.sv
// branch_pkg: opcode/rt constants and the request record shared by branch_sched and branch_cmp.
package branch_pkg;
  localparam logic [5:0] REGIMM = 6'b000001;
  localparam logic [5:0] J      = 6'b000010;
  localparam logic [5:0] JAL    = 6'b000011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] BLEZ   = 6'b000110;
  localparam logic [5:0] BGTZ   = 6'b000111;
  localparam logic [4:0] BLTZ   = 5'b00000;
  localparam logic [4:0] BGEZ   = 5'b00001;
  localparam logic [4:0] BLTZAL = 5'b10000;
  localparam logic [4:0] BGEZAL = 5'b10001;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] pc;
    logic        jump;
  } br_req_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition, kind and redirect target for one request.
module branch_cmp
  import branch_pkg::*;
(
  input  br_req_t     req,
  output logic        taken,
  output logic        is_br,
  output logic [31:0] target
);
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [31:0] pc4;
  logic        neg, zero, cond;
  always_comb begin
    op   = req.instr[31:26];
    rt   = req.instr[20:16];
    pc4  = req.pc + 32'd4;
    neg  = req.opa[31];
    zero = req.opa == 32'd0;
    cond = op == REGIMM ? ((rt == BLTZ || rt == BLTZAL) ? neg : (rt == BGEZ || rt == BGEZAL) && !neg)
         : op == BEQ    ? req.opa == req.opb
         : op == BNE    ? req.opa != req.opb
         : op == BLEZ   ? neg || zero
         : op == BGTZ   ? !neg && !zero
         : 1'b0;
    taken  = req.jump || cond;
    is_br  = req.jump || op inside {REGIMM, BEQ, BNE, BLEZ, BGTZ};
    target = req.jump ? {pc4[31:28], req.instr[25:0], 2'b00}
           : cond     ? pc4 + {{14{req.instr[15]}}, req.instr[15:0], 2'b00}
           : pc4;
  end
endmodule

// File: rtl/branch_sched.sv
// branch_sched: two-requester round-robin branch resolver, 2-stage pipeline (grant/capture, compare/result).
// Optional BRANCH_SCHED_STATS_EN adds saturating resolved/mispredict counters.
module branch_sched
  import branch_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_instr,
  input  logic [1:0][31:0]      req_opa,
  input  logic [1:0][31:0]      req_opb,
  input  logic [1:0][31:0]      req_pc,
  input  logic [1:0]            req_jump,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_taken,
  output logic                  res_is_br,
  output logic [31:0]           res_target,
  output logic                  res_mispredict,
  input  logic                  flush
`ifdef BRANCH_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_resolved,
  output logic [31:0]           stat_mispredict
`endif
);
  logic             ptr, armed, s1_valid, s2_valid, s1_free, s2_free, sel;
  logic [1:0]       grant;
  logic [TAG_W-1:0] s1_tag;
  br_req_t          s1_req, cand;
  logic             c_taken, c_is_br;
  logic [31:0]      c_target;
  // armed keeps req_ready low while reset is held, without feeding reset into combinational logic
  always_comb begin
    s2_free   = !s2_valid || res_ready;
    s1_free   = !s1_valid || s2_free;
    grant     = {req_valid[1] && (ptr || !req_valid[0]), req_valid[0] && (!ptr || !req_valid[1])};
    req_ready = (armed && s1_free && !flush) ? grant : 2'b00;
    sel       = req_ready[1];
    cand      = '{instr: req_instr[sel], opa: req_opa[sel], opb: req_opb[sel], pc: req_pc[sel], jump: req_jump[sel]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      armed    <= 1'b0;
      ptr      <= 1'b0;
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_tag   <= '0;
    end else begin
      armed <= 1'b1;
      if (|req_ready) begin
        ptr    <= req_ready[0];
        s1_req <= cand;
        s1_tag <= req_tag[sel];
      end
      if (flush) s1_valid <= 1'b0;
      else if (s1_free) s1_valid <= |req_ready;
    end
  branch_cmp u_cmp (
    .req   (s1_req),
    .taken (c_taken),
    .is_br (c_is_br),
    .target(c_target)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s2_valid   <= 1'b0;
      res_tag    <= '0;
      res_taken  <= 1'b0;
      res_is_br  <= 1'b0;
      res_target <= '0;
    end else begin
      if (flush) s2_valid <= 1'b0;
      else if (s2_free) s2_valid <= s1_valid;
      if (!flush && s2_free && s1_valid) begin
        res_tag    <= s1_tag;
        res_taken  <= c_taken;
        res_is_br  <= c_is_br;
        res_target <= c_target;
      end
    end
  assign res_valid      = s2_valid;
  assign res_mispredict = res_taken;
`ifdef BRANCH_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else if (res_valid && res_ready) begin
      stat_resolved   <= stat_resolved + {31'd0, ~&stat_resolved};
      stat_mispredict <= stat_mispredict + {31'd0, res_mispredict && ~&stat_mispredict};
    end
`endif
endmodule

// File: tb/tb_branch_sched.sv
// tb_branch_sched: scoreboard bench for branch_sched; checks stats ports when BRANCH_SCHED_STATS_EN is defined.
module tb_branch_sched;
  import branch_pkg::*;
  logic             clk = 1'b0;
  logic             reset, res_ready, flush;
  logic [1:0]       req_valid, req_ready, req_jump;
  logic [1:0][31:0] req_instr, req_opa, req_opb, req_pc;
  logic [1:0][5:0]  req_tag;
  logic             res_valid, res_taken, res_is_br, res_mispredict;
  logic [5:0]       res_tag;
  logic [31:0]      res_target;
`ifdef BRANCH_SCHED_STATS_EN
  logic [31:0]      stat_resolved, stat_mispredict;
`endif
  typedef struct {
    logic [5:0]  tag;
    logic        taken;
    logic        is_br;
    logic [31:0] target;
  } exp_t;
  exp_t        sb[$];
  int          grants[$];
  logic        got_taken[int];
  logic [31:0] got_target[int];
  int          n_chk = 0, n_fail = 0, exp_ptr = 0, hs_cnt = 0, mis_cnt = 0;
  logic        held = 1'b0;
  logic [63:0] saved;

  branch_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_opa(req_opa), .req_opb(req_opb), .req_pc(req_pc),
    .req_jump(req_jump), .req_tag(req_tag), .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_taken(res_taken), .res_is_br(res_is_br), .res_target(res_target),
    .res_mispredict(res_mispredict), .flush(flush)
`ifdef BRANCH_SCHED_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rt, logic [15:0] imm);
    return {op, 5'd3, rt, imm};
  endfunction

  // Independent reference: signed compares instead of bit tests
  function automatic exp_t model(logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] pc, logic j, logic [5:0] t);
    exp_t m;
    logic [31:0] nxt;
    logic signed [31:0] off;
    logic c, br;
    nxt = pc + 32'd4;
    off = $signed(ins[15:0]);
    c = 1'b0;
    br = 1'b0;
    case (ins[31:26])
      6'd1: begin
        br = 1'b1;
        case (ins[20:16])
          5'd0, 5'd16: c = $signed(a) < 0;
          5'd1, 5'd17: c = $signed(a) >= 0;
          default:     c = 1'b0;
        endcase
      end
      6'd4: begin br = 1'b1; c = a == b; end
      6'd5: begin br = 1'b1; c = a != b; end
      6'd6: begin br = 1'b1; c = $signed(a) <= 0; end
      6'd7: begin br = 1'b1; c = $signed(a) > 0; end
      default: ;
    endcase
    m.tag    = t;
    m.taken  = c | j;
    m.is_br  = br | j;
    m.target = j ? {nxt[31:28], ins[25:0], 2'b00} : c ? nxt + 32'(off * 4) : nxt;
    return m;
  endfunction

  task automatic drive(int i, logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                       logic [31:0] pc, logic j, logic [5:0] t);
    req_valid[i] = 1'b1;
    req_instr[i] = ins;
    req_opa[i]   = a;
    req_opb[i]   = b;
    req_pc[i]    = pc;
    req_jump[i]  = j;
    req_tag[i]   = t;
  endtask

  // Samples 3ns before the rising edge, then returns at the next falling edge
  task automatic tick();
    exp_t e;
    #2;
    if (held && res_valid)
      chk("hold", {23'd0, res_tag, res_taken, res_is_br, res_target, res_mispredict}, saved);
    if (res_valid && res_ready) begin
      hs_cnt++;
      got_taken[int'(res_tag)]  = res_taken;
      got_target[int'(res_tag)] = res_target;
      if (sb.size() == 0) chk("spurious_result", {63'd0, res_valid}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("tag", res_tag, e.tag);
        chk("taken", res_taken, e.taken);
        chk("is_br", res_is_br, e.is_br);
        chk("target", res_target, e.target);
        chk("mispredict", res_mispredict, e.taken);
        if (e.taken) mis_cnt++;
      end
    end
    held  = res_valid && !res_ready;
    saved = {23'd0, res_tag, res_taken, res_is_br, res_target, res_mispredict};
    chk("one_hot", 64'($countones(req_ready) <= 1), 64'd1);
    if (flush) begin
      chk("flush_ready", req_ready, 2'b00);
      sb.delete();
    end
    for (int i = 0; i < 2; i++)
      if (req_valid[i] && req_ready[i]) begin
        if (&req_valid) chk("rr_grant", i, exp_ptr);
        exp_ptr = 1 - i;
        grants.push_back(i);
        sb.push_back(model(req_instr[i], req_opa[i], req_opb[i], req_pc[i], req_jump[i], req_tag[i]));
      end
    @(negedge clk);
  endtask

  task automatic send(int i, logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                      logic [31:0] pc, logic j, logic [5:0] t);
    int n0;
    n0 = grants.size();
    drive(i, ins, a, b, pc, j, t);
    for (int k = 0; k < 10 && grants.size() == n0; k++) tick();
    chk("granted", 64'(grants.size() > n0), 64'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    req_valid = 2'b00;
    res_ready = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    chk("drained", sb.size(), 0);
    tick();
    chk("idle", res_valid, 0);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tag", res_tag, 0);
    chk("rst_target", res_target, 0);
    chk("rst_taken", {res_taken, res_mispredict, res_is_br}, 0);
    reset = 1'b0;
    sb.delete();
    exp_ptr = 0;
    held = 1'b0;
    hs_cnt = 0;
    mis_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[8];
    logic [4:0] rts[5];
    logic [31:0] avals[4];
    int n0;
    ops   = '{REGIMM, BEQ, BNE, BLEZ, BGTZ, J, 6'h23, REGIMM};
    rts   = '{BLTZ, BGEZ, BLTZAL, BGEZAL, 5'd5};
    avals = '{32'd0, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF};
    reset = 1'b1;
    req_valid = 2'b11;
    req_instr = '0; req_opa = '0; req_opb = '0; req_pc = '0; req_jump = '0; req_tag = '0;
    res_ready = 1'b1;
    flush = 1'b0;
    #1;
    chk("init_res_valid", res_valid, 0);
    chk("init_req_ready", req_ready, 0);
    chk("init_outs", {res_tag, res_taken, res_is_br, res_mispredict, res_target}, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b00;
    tick();
    // Single BEQ: result two cycles after the transfer
    drive(0, mk(BEQ, 5'd0, 16'h0004), 32'd5, 32'd5, 32'h100, 1'b0, 6'd1);
    tick();
    chk("beq_accepted", grants.size(), 1);
    req_valid = 2'b00;
    chk("beq_not_yet", res_valid, 0);
    tick();
    chk("beq_valid", res_valid, 1);
    chk("beq_taken", res_taken, 1);
    chk("beq_target", res_target, 32'h114);
    chk("beq_mispredict", res_mispredict, 1);
    chk("beq_tag", res_tag, 1);
    drain();
    // Both requesters contending right after reset
    pulse_reset();
    grants.delete();
    drive(0, mk(BNE, 5'd0, 16'h0008), 32'd1, 32'd2, 32'h400, 1'b0, 6'd10);
    drive(1, mk(REGIMM, BGEZ, 16'hFFF0), 32'd9, 32'd0, 32'h500, 1'b0, 6'd20);
    for (int k = 0; k < 8 && grants.size() < 4; k++) begin
      n0 = grants.size();
      tick();
      if (grants.size() > n0) req_tag[grants[$]] = req_tag[grants[$]] + 6'd1;
    end
    chk("alt_count", grants.size(), 4);
    foreach (grants[i]) chk("alt_order", grants[i], i % 2);
    drain();
    // BGTZ on zero, then BLTZ on negative
    send(0, mk(BGTZ, 5'd0, 16'h0010), 32'd0, 32'd0, 32'h200, 1'b0, 6'd30);
    send(0, mk(REGIMM, BLTZ, 16'hFFFE), 32'h8000_0000, 32'd0, 32'h300, 1'b0, 6'd31);
    drain();
    chk("bgtz_taken", got_taken[30], 0);
    chk("bgtz_target", got_target[30], 32'h204);
    chk("bltz_taken", got_taken[31], 1);
    chk("bltz_target", got_target[31], 32'h2FC);
    // Consumer stall with both stages full
    res_ready = 1'b0;
    send(0, mk(BEQ, 5'd0, 16'h0001), 32'd3, 32'd4, 32'h600, 1'b0, 6'd40);
    send(0, 32'h0800_0040, 32'd0, 32'd0, 32'h1000_0000, 1'b1, 6'd41);
    drive(0, mk(BLEZ, 5'd0, 16'h0002), 32'd0, 32'd0, 32'h700, 1'b0, 6'd42);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", res_valid, 1);
      tick();
    end
    n0 = hs_cnt;
    res_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    chk("release_two", hs_cnt - n0, 2);
    drain();
    // Flush with both stages occupied
    res_ready = 1'b0;
    send(0, mk(BNE, 5'd0, 16'h0003), 32'd1, 32'd1, 32'h800, 1'b0, 6'd50);
    send(0, mk(BGTZ, 5'd0, 16'h0003), 32'd1, 32'd1, 32'h900, 1'b0, 6'd51);
    drive(0, mk(BEQ, 5'd0, 16'h0001), 32'd0, 32'd0, 32'hA00, 1'b0, 6'd52);
    drive(1, mk(BEQ, 5'd0, 16'h0001), 32'd0, 32'd0, 32'hB00, 1'b0, 6'd53);
    flush = 1'b1;
    #1;
    chk("flush_req_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    chk("post_flush_valid", res_valid, 0);
    grants.delete();
    for (int k = 0; k < 3 && grants.size() == 0; k++) tick();
    chk("ptr_kept", grants.size() > 0 ? grants[0] : -1, 1);
    drain();
    // Asynchronous reset while stalled
    res_ready = 1'b0;
    send(0, mk(BEQ, 5'd0, 16'h0005), 32'd2, 32'd2, 32'hC00, 1'b0, 6'd60);
    send(1, mk(BNE, 5'd0, 16'h0005), 32'd2, 32'd2, 32'hD00, 1'b0, 6'd61);
    drive(0, mk(BLEZ, 5'd0, 16'h0001), 32'd5, 32'd0, 32'hE00, 1'b0, 6'd62);
    drive(1, mk(BLEZ, 5'd0, 16'h0001), 32'd5, 32'd0, 32'hF00, 1'b0, 6'd63);
    tick();
    res_ready = 1'b1;
    pulse_reset();
    chk("post_reset_valid", res_valid, 0);
    grants.delete();
    for (int k = 0; k < 3 && grants.size() == 0; k++) tick();
    chk("reset_first_grant", grants.size() > 0 ? grants[0] : -1, 0);
    drain();
    // Randomised traffic with stalls and occasional flushes
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, {ops[$urandom_range(0, 7)], 5'($urandom), rts[$urandom_range(0, 4)], 16'($urandom)},
              $urandom_range(0, 4) == 4 ? $urandom : avals[$urandom_range(0, 3)],
              $urandom_range(0, 1) == 1 ? avals[$urandom_range(0, 3)] : $urandom,
              $urandom, $urandom_range(0, 5) == 0, 6'($urandom));
      req_valid = 2'($urandom);
      res_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      tick();
    end
    drain();
`ifdef BRANCH_SCHED_STATS_EN
    chk("stat_resolved", stat_resolved, hs_cnt);
    chk("stat_mispredict", stat_mispredict, mis_cnt);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
